// File: rtl/memory_bus_master_if.sv
// Core request/response port and memory bus port of memory_bus_master, bundled
// with a master (block side) and slave (core plus responder side) view.
interface memory_bus_master_if;
  logic        request_valid;
  logic        request_ready;
  logic [31:0] request_address;
  logic        request_write;
  logic [1:0]  request_size;
  logic        request_signed;
  logic [31:0] request_data;
  logic        response_valid;
  logic [31:0] response_data;
  logic [1:0]  response_error;
  logic [31:0] memory_address;
  logic [31:0] memory_data_in;
  logic [31:0] memory_data_out;
  logic [1:0]  memory_data_size;
  logic        memory_enable;
  logic        memory_operation;
  logic        memory_ready;

  modport master (
    input  request_valid, request_address, request_write, request_size,
           request_signed, request_data, memory_data_in, memory_ready,
    output request_ready, response_valid, response_data, response_error,
           memory_address, memory_data_out, memory_data_size, memory_enable,
           memory_operation
  );

  modport slave (
    output request_valid, request_address, request_write, request_size,
           request_signed, request_data, memory_data_in, memory_ready,
    input  request_ready, response_valid, response_data, response_error,
           memory_address, memory_data_out, memory_data_size, memory_enable,
           memory_operation
  );
endinterface

// File: rtl/memory_bus_master.sv
// CPU-side memory bus initiator: one load/store at a time, enable/ready
// four-phase handshake, alignment and timeout errors, extended load data.
module memory_bus_master #(
  parameter int unsigned timeout_cycles = 255
) (
  input logic                 clock,
  input logic                 reset,
  memory_bus_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, ENABLE, RELEASE, RESPOND} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_op_q, mem_op_d;
  logic        signed_q, signed_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic        misaligned;
  logic [31:0] wdata_masked;
  logic [31:0] load_ext;

  always_comb begin
    misaligned = ((bus.request_size == 2'd1) && bus.request_address[0]) ||
                 ((bus.request_size == 2'd2) && (bus.request_address[1:0] != 2'b00));
    case (bus.request_size)
      2'd0:    wdata_masked = {24'h0, bus.request_data[7:0]};
      2'd1:    wdata_masked = {16'h0, bus.request_data[15:0]};
      default: wdata_masked = bus.request_data;
    endcase
    case (mem_size_q)
      2'd0:    load_ext = {{24{signed_q & rdata_q[7]}}, rdata_q[7:0]};
      2'd1:    load_ext = {{16{signed_q & rdata_q[15]}}, rdata_q[15:0]};
      default: load_ext = rdata_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_data_d  = '0;
    rsp_err_d   = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    mem_en_d    = 1'b0;
    mem_op_d    = mem_op_q;
    signed_d    = signed_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        // Error paths answer straight away and leave the bus registers alone.
        if (req_ready_q && bus.request_valid) begin
          if (bus.request_size == 2'd3) begin
            state_d   = RESPOND;
            rsp_err_d = 2'd3;
          end else if (misaligned) begin
            state_d   = RESPOND;
            rsp_err_d = 2'd1;
          end else begin
            state_d     = ENABLE;
            mem_en_d    = 1'b1;
            mem_addr_d  = bus.request_address;
            mem_wdata_d = wdata_masked;
            mem_size_d  = bus.request_size;
            mem_op_d    = bus.request_write;
            signed_d    = bus.request_signed;
            cnt_d       = '0;
            err_d       = '0;
            rdata_d     = '0;
          end
        end
      end
      ENABLE: begin
        if (bus.memory_ready) begin
          state_d = RELEASE;
          if (!mem_op_q) rdata_d = bus.memory_data_in;
        end else if ((timeout_cycles != 0) && (cnt_q + 32'd1 == timeout_cycles)) begin
          state_d = RELEASE;
          err_d   = 2'd2;
        end else begin
          cnt_d    = cnt_q + 32'd1;
          mem_en_d = 1'b1;
        end
      end
      RELEASE: begin
        if (!bus.memory_ready) begin
          state_d    = RESPOND;
          rsp_err_d  = err_q;
          rsp_data_d = ((err_q != 2'd0) || mem_op_q) ? '0 : load_ext;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESPOND);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_op_q    <= 1'b0;
      signed_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      mem_en_q    <= mem_en_d;
      mem_op_q    <= mem_op_d;
      signed_q    <= signed_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.request_ready    = req_ready_q;
  assign bus.response_valid   = rsp_valid_q;
  assign bus.response_data    = rsp_data_q;
  assign bus.response_error   = rsp_err_q;
  assign bus.memory_address   = mem_addr_q;
  assign bus.memory_data_out  = mem_wdata_q;
  assign bus.memory_data_size = mem_size_q;
  assign bus.memory_enable    = mem_en_q;
  assign bus.memory_operation = mem_op_q;

endmodule

// File: doc/memory_bus_master.md
Name: memory_bus_master

Overview:
- CPU-side initiator for the memory bus (enable/ready four-phase handshake, byte/half/word sizes).
- Accepts one load/store request at a time from the core over a valid/ready port.
- Checks alignment and drives the bus through a full enable/ready cycle.
- Returns sign- or zero-extended load data, or an error code, as a one-cycle response pulse.

Parameters:
- timeout_cycles, 255: maximum clock edges memory_enable waits for memory_ready; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- request_valid  in  1  core request present
- request_ready  out  1  block idle and accepting
- request_address  in  32  byte address
- request_write  in  1  0 = load, 1 = store
- request_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- request_signed  in  1  sign-extend load result
- request_data  in  32  store data, low bits used
- response_valid  out  1  one-cycle completion pulse
- response_data  out  32  extended load data; 0 for stores and errors
- response_error  out  2  0 = ok, 1 = misaligned, 2 = timeout, 3 = illegal size
- memory_address  out  32  bus address
- memory_data_in  in  32  read data from responder
- memory_data_out  out  32  write data
- memory_data_size  out  2  bus size code
- memory_enable  out  1  bus request strobe
- memory_operation  out  1  0 = read, 1 = write
- memory_ready  in  1  responder acknowledge

Behaviour:
- Reset (reset = 0, asynchronous): all outputs 0, including request_ready; FSM to IDLE; timeout counter cleared.
  - Reset mid-transaction drops memory_enable immediately and discards the request; no response is issued.
- All outputs are registered. memory_ready is sampled only on rising clock edges.
- IDLE: request_ready = 1. On an edge with request_valid = 1, latch address, write, size, signed and data; request_ready falls next cycle.
  - size = 3 -> error 3, go to RESPOND.
  - Half with address[0] = 1, or word with address[1:0] != 0 -> error 1, go to RESPOND.
  - Otherwise go to ENABLE.
  - In both error paths the bus is never touched.
- ENABLE: memory_enable = 1. memory_address, memory_data_size and memory_operation are stable for the whole state. memory_data_out = request_data with bits above the size zeroed.
  - Edge with memory_ready = 1: capture memory_data_in (loads only), go to RELEASE.
  - Counter increments each edge without ready. When counter reaches timeout_cycles (nonzero): error 2, go to RELEASE.
- RELEASE: memory_enable = 0; bus address, size, operation and data stay held. Wait for an edge with memory_ready = 0, then go to RESPOND. There is no timeout in this state.
- RESPOND: response_valid = 1 for exactly one cycle, then IDLE. The next request can be accepted on the edge after response_valid falls.
- Load extension:
  - size 0: signed -> {24{d[7]}, d[7:0]}; unsigned -> zero-extended.
  - size 1: same rule using d[15].
  - size 2: d passed through.
- response_data = 0 for stores and for any error.
- Latency with a zero-wait responder (ready rises within the enable cycle, falls within the release cycle):
  - Accept edge E0; enable high E0–E1; RELEASE E1–E2; response_valid high E2–E3.
  - Total 3 cycles from accept to response.
- memory_ready already high on entry to ENABLE counts as an acknowledge. The responder is responsible for having released it.
- request_valid while not IDLE is ignored; request_ready = 0.

Test Plan:
- Word load, addr 0x100, memory returns 0x8000_00F0 with zero wait -> one enable pulse, size 2, op 0; response_valid 3 cycles after accept; data 0x800000F0, error 0.
- Signed byte load, addr 0x101, memory data 0x000000F0 -> response 0xFFFFFFF0; same load unsigned -> 0x000000F0; signed half with data 0x7FFF -> 0x00007FFF.
- Half store 0xABCD1234, addr 0x202, 4-cycle ready delay -> memory_data_out 0x00001234; enable held until ready; response_data 0, error 0.
- Word load, addr 0x102 -> error 1; size 3 -> error 3; memory_enable never asserts; response 1 cycle after accept.
- timeout_cycles = 8, ready never asserted -> enable high 8 cycles, then low; error 2; block returns to IDLE and accepts the next request.
- Reset asserted while enable is high and ready is pending -> enable low asynchronously, no response_valid; after release, request_ready = 1 and a word load completes normally.
